maxpool2x2_stream: RTL
======================

Name: maxpool2x2_stream

Overview:
- Downstream consumer of the 2-D convolution core. Takes the raster-order fp32 output stream (one pixel per valid cycle, no backpressure) and applies optional ReLU.
- Performs a 2x2 stride-2 max-pool and emits a half-resolution raster stream for the next layer or the DMA writer.
- Uses one on-chip line buffer of pairwise column maxima from the even row.

Parameters:
- C_WIDTH, 9, bit width of the map width/height parameters; maximum input width is 2^C_WIDTH-1.
- LINE_DEPTH, 256, line-buffer entries; must be at least floor(max width/2).
- LB_AW, 8, line-buffer address width; equals log2(LINE_DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- param_ena  in  1  latch configuration; accepted only in IDLE, ignored otherwise
- param_width  in  C_WIDTH  input map width W, must be >=2
- param_height  in  C_WIDTH  input map height H, must be >=2
- param_relu  in  1  1 = clamp negative inputs to +0.0 before pooling
- pxl_ena_in  in  1  input pixel valid (conv core output enable)
- pxl_z  in  32  input pixel, IEEE-754 single
- pool_ena_out  out  1  output pixel valid, one-cycle pulse per output
- pool_data  out  32  pooled pixel, IEEE-754 single
- frame_done  out  1  one-cycle pulse after the last input pixel of a frame
- busy  out  1  high in RUN state

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; pool_ena_out=0, pool_data=0, frame_done=0, busy=0; col/row counters=0; config registers=0 (W=H=0, relu=0). Line-buffer contents are don't-care.
- Config: W, H and relu are registered on param_ena while in IDLE. They are held constant through RUN. param_ena in RUN or DONE has no effect.
- FSM:
  - IDLE -> RUN on pxl_ena_in (that pixel is processed as col 0, row 0).
  - RUN -> DONE when accepting the pixel at col W-1, row H-1.
  - DONE -> IDLE after 1 cycle; frame_done=1 during DONE.
  - A pxl_ena_in during DONE is a protocol violation; it is dropped and the counters are not disturbed.
- Counters: col increments on each accepted pixel and wraps to 0 after W-1, at which point row increments. Both clear on entering IDLE.
- ReLU: if relu=1 and the sign bit=1, the value becomes 32'h0000_0000 (this includes -0.0 -> +0.0).
- Float max: key(x) = x[31] ? ~x : x ^ 32'h8000_0000; unsigned compare of keys. max(a,b) returns the operand with the larger key; on a tie it returns a (the earlier/left pixel). NaNs are not special-cased; they order by bit pattern under this key.
- Horizontal pair: at even col the pixel is held in hold_reg. At odd col, hmax = max(hold_reg, pixel).
- Even row, odd col: line_buf[col>>1] <= hmax. No output.
- Odd row, odd col:
  - Output = max(line_buf[col>>1], hmax).
  - pool_ena_out=1 and pool_data=result, registered: exactly 1 cycle after the accepted input pixel at odd col.
  - Line-buffer read is addressed at even col so the data is ready at odd col, including back-to-back input.
- Odd W: the last column (col=W-1, even) is loaded into hold_reg and never used. Odd H: the last row is processed as even and writes line_buf, but produces no output.
- Output count per frame = floor(W/2)*floor(H/2), in raster order of the pooled map. pool_data holds its last value when pool_ena_out=0.
- Gaps in pxl_ena_in are allowed anywhere; state is frozen while it is low. Throughput is 1 pixel/cycle sustained.
- Read/write hazards: in an even row the buffer is only written; in an odd row it is only read. No same-address read/write collision occurs. Sizing rule: floor(W/2) <= LINE_DEPTH; larger W is unsupported.
- Reset mid-frame aborts immediately. After release the block is in IDLE and needs a new param_ena; no stale output pulses appear.

Test Plan:
- W=4,H=4,relu=0, inputs 1.0..16.0 raster -> exactly 4 outputs: 6.0, 8.0, 14.0, 16.0; each pool_ena_out exactly 1 cycle after input index 5, 7, 13, 15; frame_done 1 cycle after input 16.
- W=5,H=3,relu=0, all inputs -2.0 except row1 col3 = -0.5 -> outputs -2.0, -0.5 only (2 outputs); the dropped col 4 and row 2 never appear.
- W=4,H=2,relu=1, inputs -3.0,-1.0,-7.0,-2.0 / -5.0,-4.0,-0.0,-6.0 -> outputs 0x00000000, 0x00000000. Same with relu=0 -> -1.0 (0xBF800000) and -0.0 (0x80000000; -0.0 has the largest key among the four).
- W=8,H=2 input with random 0-3 idle cycles between pixels -> outputs identical to the gap-free run; output count 4.
- Assert rst_n low after 6 pixels of a 4x4 frame, release, reprogram W=2,H=2 and send 1.0,3.0,2.0,0.5 -> single output 3.0; no output from the aborted frame.
- param_ena with W=6 during RUN of a W=4 frame -> ignored; frame completes with 4-wide pooling; next frame uses W=4.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 max-pool with optional ReLU for
// fp32 raster pixels from the convolution core. The even row of each pool
// window is reduced pairwise into a line buffer. The odd row is then reduced
// against that buffer and emits one pooled pixel per 2x2 window.
module maxpool2x2_stream #(
  parameter int C_WIDTH    = 9,
  parameter int LINE_DEPTH = 256,
  parameter int LB_AW      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               param_ena,
  input  logic [C_WIDTH-1:0] param_width,
  input  logic [C_WIDTH-1:0] param_height,
  input  logic               param_relu,
  input  logic               pxl_ena_in,
  input  logic [31:0]        pxl_z,
  output logic               pool_ena_out,
  output logic [31:0]        pool_data,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Map an IEEE-754 single to an unsigned key whose ordering matches the
  // float ordering (negatives inverted, positives offset above them).
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Larger of two floats by key; a tie keeps the first (earlier) operand.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  // Control state
  logic [1:0]         state_q, state_d;
  logic [C_WIDTH-1:0] cfg_w_q, cfg_w_d;
  logic [C_WIDTH-1:0] cfg_h_q, cfg_h_d;
  logic               cfg_relu_q, cfg_relu_d;
  logic [C_WIDTH-1:0] col_q, col_d;
  logic [C_WIDTH-1:0] row_q, row_d;
  logic [31:0]        hold_q, hold_d;

  // Output registers
  logic               pool_ena_q;
  logic [31:0]        pool_data_q;

  // Line buffer of even-row pair maxima, with a registered read port
  logic [31:0]        line_buf [LINE_DEPTH];
  logic [31:0]        lb_rd_q;

  // Datapath helpers
  logic               pix_acc;
  logic [31:0]        px_act;
  logic [31:0]        hmax;
  logic [31:0]        vmax;
  logic               col_last;
  logic               row_last;
  logic               col_odd;
  logic               row_odd;
  logic [LB_AW-1:0]   lb_addr;
  logic               lb_we;
  logic               lb_re;
  logic               out_fire;

  // Pixels are taken in IDLE (first pixel of a frame) and RUN; a pixel that
  // arrives in DONE is a protocol violation and is simply discarded.
  assign pix_acc  = pxl_ena_in && ((state_q == ST_IDLE) || (state_q == ST_RUN));

  // ReLU clamps every sign-set value, including -0.0, to +0.0.
  assign px_act   = (cfg_relu_q && pxl_z[31]) ? 32'h0000_0000 : pxl_z;

  assign col_last = (col_q == (cfg_w_q - C_WIDTH'(1)));
  assign row_last = (row_q == (cfg_h_q - C_WIDTH'(1)));
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];

  // Horizontal pair max (left pixel held from the even column) and the
  // vertical max against the pair from the row above.
  assign hmax     = fmax(hold_q, px_act);
  assign vmax     = fmax(lb_rd_q, hmax);

  // One buffer slot per column pair. Even rows only write, odd rows only
  // read, so the same address is never read and written together. The read
  // is issued at the even column so data is waiting at the odd column even
  // with no idle cycle in between.
  assign lb_addr  = col_q[LB_AW:1];
  assign lb_we    = pix_acc && col_odd && !row_odd;
  assign lb_re    = pix_acc && !col_odd && row_odd;
  assign out_fire = pix_acc && col_odd && row_odd;

  // Next-state logic: FSM, configuration capture, raster counters, hold reg
  always_comb begin
    state_d    = state_q;
    cfg_w_d    = cfg_w_q;
    cfg_h_d    = cfg_h_q;
    cfg_relu_d = cfg_relu_q;
    col_d      = col_q;
    row_d      = row_q;
    hold_d     = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (param_ena) begin
          cfg_w_d    = param_width;
          cfg_h_d    = param_height;
          cfg_relu_d = param_relu;
        end
      end
      ST_RUN: begin
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase

    if (pix_acc) begin
      // Even columns park the left pixel; on odd W the final even column is
      // parked and never consumed.
      if (!col_odd) begin
        hold_d = px_act;
      end

      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d   = '0;
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + C_WIDTH'(1);
          state_d = ST_RUN;
        end
      end else begin
        col_d   = col_q + C_WIDTH'(1);
        state_d = ST_RUN;
      end
    end
  end

  // Control and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_w_q    <= '0;
      cfg_h_q    <= '0;
      cfg_relu_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_w_q    <= cfg_w_d;
      cfg_h_q    <= cfg_h_d;
      cfg_relu_q <= cfg_relu_d;
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
    end
  end

  // Pooled output: one-cycle valid pulse, data holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_ena_q  <= 1'b0;
      pool_data_q <= '0;
    end else begin
      pool_ena_q <= out_fire;
      if (out_fire) begin
        pool_data_q <= vmax;
      end
    end
  end

  // Line buffer: plain array with registered read so it maps to block RAM
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_addr] <= hmax;
    end
    if (lb_re) begin
      lb_rd_q <= line_buf[lb_addr];
    end
  end

  assign pool_ena_out = pool_ena_q;
  assign pool_data    = pool_data_q;
  assign frame_done   = (state_q == ST_DONE);
  assign busy         = (state_q == ST_RUN);

endmodule
